adder32_rr_arbiter: RTL and testbench
=====================================

// Module: adder32_rr_arbiter
// PURPOSE
//  Shares a single 32-bit adder (sum + carry-out) between NREQ requesters.
//  A round-robin arbiter picks one pending request per cycle and holds the
//  result in a one-entry output register with valid/ready backpressure.
//  Each result is tagged with the winning requester's index.
//  Sits between client blocks issuing 32-bit adds and the shared adder datapath.
// PARAMETERS
//  NREQ    4   number of requesters (2..8)
//  IDW     2   width of requester id; must equal clog2(NREQ), minimum 1
//  CNTW    16  width of the completed-operation counter
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        synchronous reset, active-low
//  req        in   NREQ     req[i]=1: requester i has valid operands
//  a_flat     in   NREQ*32  operand A of requester i at bits [32*i+31:32*i]
//  b_flat     in   NREQ*32  operand B of requester i, same packing as a_flat
//  gnt        out  NREQ     one-hot (or zero) accept strobe; combinational
//  res_valid  out  1        output register holds a result
//  res_ready  in   1        downstream consumes the result this cycle
//  res_sum    out  32       (A+B)[31:0]
//  res_carry  out  1        (A+B)[32]
//  res_id     out  IDW      index of the requester that produced the result
//  op_count   out  CNTW     number of results consumed since reset
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk):
//   - res_valid=0, res_sum=0, res_carry=0, res_id=0, op_count=0.
//   - RR pointer=0 (requester 0 has highest priority).
//   - Any held result is discarded.
//  Reset dominates every other event in the same cycle.
//  Handshake:
//   - Requester i raises req[i] with stable operands and holds both until it
//     samples gnt[i]=1 at a posedge; that edge is the transfer.
//   - It may drop req[i] afterwards or present new operands with req[i]=1.
//   - Dropping req before grant is legal; no transfer occurs.
//  Accept condition: accept = |req & (!res_valid | res_ready).
//   - gnt is zero whenever accept=0.
//   - gnt is combinational from req, res_valid, res_ready and the pointer.
//  Arbitration, round-robin:
//   - Search starts at the pointer index and wraps modulo NREQ.
//   - The first set req bit wins.
//   - On accept, pointer <= (winner+1) mod NREQ; otherwise pointer holds.
//   - Wrap case: pointer=NREQ-1 and the winner is NREQ-1 gives pointer 0.
//  Datapath:
//   - On accept: {res_carry,res_sum} <= A_w + B_w, computed 33 bits wide with
//     no truncation of the carry.
//   - Also on accept: res_id <= winner and res_valid <= 1.
//   - Latency: the result is visible on the cycle after the grant.
//  Output register states:
//   - EMPTY (res_valid=0): accepts when |req.
//   - FULL (res_valid=1):
//     - res_ready=1 and |req: drain and refill in the same cycle
//       (back-to-back, 1 op/cycle).
//     - res_ready=1 and no req: res_valid <= 0.
//     - res_ready=0: sum, carry and id hold stable; gnt=0.
//  op_count increments by 1 on each cycle with res_valid & res_ready.
//   - It wraps from 2^CNTW-1 to 0 silently.
//  res_ready while res_valid=0 is ignored.
//  No result is lost, duplicated or reordered.
// TESTING
//  1 Reset: hold rst_n=0 with req=all-ones -> gnt=0, res_valid=0,
//    op_count=0; first grant after release goes to requester 0.
//  2 Single op: req=0001, A0=32'h0000_0001, B0=32'hFFFF_FFFF, res_ready=1
//    -> gnt=0001; next cycle res_valid=1, sum=0, carry=1, id=0.
//  3 Fairness: req=1111 held for 8 cycles, res_ready=1 -> grant order
//    0,1,2,3,0,1,2,3; one result per cycle; op_count=8 two cycles after
//    the last grant.
//  4 Backpressure: result FULL, res_ready=0 for 5 cycles with req=0110
//    -> gnt=0, outputs stable; res_ready=1 -> drain and grant in the same
//    cycle, pointer continues round-robin.
//  5 Carry/width: A=B=32'h8000_0000 -> sum=0, carry=1;
//    A=32'h7FFF_FFFF, B=1 -> sum=32'h8000_0000, carry=0.
//  6 Reset mid-op: rst_n=0 while FULL and req pending -> res_valid=0 next
//    edge; held result dropped; pointer=0.

Source files
------------

// File: rtl/adder32_rr_if.sv
// Request/result bundle between adder clients and the shared round-robin adder.
// The master side is the client group; the slave side is the arbiter.
interface adder32_rr_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
);
    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] a_flat;
    logic [NREQ*32-1:0] b_flat;
    logic [NREQ-1:0]    gnt;
    logic               res_valid;
    logic               res_ready;
    logic [31:0]        res_sum;
    logic               res_carry;
    logic [IDW-1:0]     res_id;
    logic [CNTW-1:0]    op_count;

    modport master (
        output req, a_flat, b_flat, res_ready,
        input  gnt, res_valid, res_sum, res_carry, res_id, op_count
    );

    modport slave (
        input  req, a_flat, b_flat, res_ready,
        output gnt, res_valid, res_sum, res_carry, res_id, op_count
    );
endinterface

// File: rtl/adder32_rr_arbiter.sv
// One 32-bit adder shared by NREQ requesters through a round-robin arbiter,
// with a one-entry tagged result register under valid/ready backpressure.
//
//  state | meaning
//  EMPTY | result register free; any pending request is granted
//  FULL  | result held; refill only when the consumer drains this cycle
module adder32_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input logic         clk,
    input logic         rst_n,
    adder32_rr_if.slave bus
);

    if (IDW != $clog2(NREQ) || NREQ < 2 || NREQ > 8) begin : g_param_check
        $error("adder32_rr_arbiter: IDW must equal clog2(NREQ) with NREQ in 2..8");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  ptr_next;
    logic            found;
    logic            accept;
    int              idx;
    logic [31:0]     a_w;
    logic [31:0]     b_w;
    logic [32:0]     sum_w;
    logic [31:0]     sum_q;
    logic            carry_q;
    logic [IDW-1:0]  id_q;
    logic [CNTW-1:0] count_q;

    // Scanning from the far end lets the nearest requester (from ptr) win last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (bus.req[idx[IDW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
    end

    // Grant is suppressed during reset so no requester sees a phantom transfer.
    assign accept   = rst_n && found && ((state == EMPTY) || bus.res_ready);
    assign bus.gnt  = accept ? (NREQ'(1) << winner) : '0;
    assign ptr_next = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);

    assign a_w   = bus.a_flat[32*winner +: 32];
    assign b_w   = bus.b_flat[32*winner +: 32];
    assign sum_w = {1'b0, a_w} + {1'b0, b_w};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= EMPTY;
            ptr     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= '0;
            count_q <= '0;
        end else begin
            if (state == FULL && bus.res_ready) begin
                count_q <= count_q + CNTW'(1);
            end
            if (accept) begin
                ptr <= ptr_next;
            end
            case (state)
                EMPTY: begin
                    if (accept) begin
                        {carry_q, sum_q} <= sum_w;
                        id_q             <= winner;
                        state            <= FULL;
                    end
                end
                FULL: begin
                    if (bus.res_ready) begin
                        if (accept) begin
                            {carry_q, sum_q} <= sum_w;
                            id_q             <= winner;
                        end else begin
                            state <= EMPTY;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.res_valid = (state == FULL);
    assign bus.res_sum   = sum_q;
    assign bus.res_carry = carry_q;
    assign bus.res_id    = id_q;
    assign bus.op_count  = count_q;

endmodule

// File: tb/tb_adder32_rr_arbiter.sv
// Directed bench for adder32_rr_arbiter: inputs change on the falling edge,
// outputs are checked on the falling edge (registered) or 1 ns later (gnt).
module tb_adder32_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    adder32_rr_if #(.NREQ(4), .IDW(2), .CNTW(16)) bus ();

    adder32_rr_arbiter #(.NREQ(4), .IDW(2), .CNTW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Fairness operands and their hand-computed 33-bit sums.
    logic [31:0] fa [4] = '{32'h0000_0010, 32'hFFFF_FFF0, 32'h1234_5678, 32'hF000_0000};
    logic [31:0] fb [4] = '{32'h0000_0020, 32'h0000_0020, 32'h1111_1111, 32'h2000_0001};
    logic [31:0] fs [4] = '{32'h0000_0030, 32'h0000_0010, 32'h2345_6789, 32'h1000_0001};
    logic        fc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.a_flat[32*i +: 32] = a;
        bus.b_flat[32*i +: 32] = b;
    endtask

    task automatic chk_res(input string tag, input logic [31:0] s, input logic c, input logic [1:0] id);
        chk({tag, "_valid"}, 64'(bus.res_valid), 64'd1);
        chk({tag, "_sum"},   64'(bus.res_sum),   64'(s));
        chk({tag, "_carry"}, 64'(bus.res_carry), 64'(c));
        chk({tag, "_id"},    64'(bus.res_id),    64'(id));
    endtask

    initial begin
        // 1: reset with all requests raised
        rst_n         = 1'b0;
        bus.req       = 4'b1111;
        bus.res_ready = 1'b1;
        bus.a_flat    = '0;
        bus.b_flat    = '0;
        set_op(0, 32'h0000_0001, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        #1 chk("rst_gnt", 64'(bus.gnt), 64'd0);
        chk("rst_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_count", 64'(bus.op_count), 64'd0);
        chk("rst_sum",   64'(bus.res_sum), 64'd0);
        chk("rst_id",    64'(bus.res_id), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("first_gnt", 64'(bus.gnt), 64'b0001);
        @(negedge clk);
        bus.req = 4'b0000;
        chk_res("first_res", 32'h0, 1'b1, 2'd0);
        @(negedge clk);
        chk("first_drain", 64'(bus.res_valid), 64'd0);
        chk("first_count", 64'(bus.op_count), 64'd1);

        // 2: single op from requester 0 with pointer now at 1
        bus.req = 4'b0001;
        #1 chk("single_gnt", 64'(bus.gnt), 64'b0001);
        @(negedge clk);
        bus.req = 4'b0000;
        chk_res("single_res", 32'h0, 1'b1, 2'd0);
        @(negedge clk);
        chk("single_count", 64'(bus.op_count), 64'd2);

        // 3: fairness from a fresh pointer
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, fa[i], fb[i]);
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) chk_res($sformatf("fair_res%0d", c - 1), fs[(c-1)%4], fc[(c-1)%4], 2'((c-1)%4));
            #1 chk($sformatf("fair_gnt%0d", c), 64'(bus.gnt), 64'(4'b0001 << (c % 4)));
            @(negedge clk);
        end
        bus.req = 4'b0000;
        chk_res("fair_res7", fs[3], fc[3], 2'd3);
        chk("fair_count7", 64'(bus.op_count), 64'd7);
        @(negedge clk);
        chk("fair_count8", 64'(bus.op_count), 64'd8);
        chk("fair_empty",  64'(bus.res_valid), 64'd0);

        // 4: backpressure with the register full
        bus.res_ready = 1'b0;
        bus.req       = 4'b0001;
        #1 chk("bp_fill_gnt", 64'(bus.gnt), 64'b0001);
        @(negedge clk);
        bus.req = 4'b0110;
        for (int c = 0; c < 5; c++) begin
            #1 chk($sformatf("bp_gnt%0d", c), 64'(bus.gnt), 64'd0);
            chk_res($sformatf("bp_hold%0d", c), fs[0], fc[0], 2'd0);
            chk($sformatf("bp_count%0d", c), 64'(bus.op_count), 64'd8);
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        #1 chk("bp_release_gnt", 64'(bus.gnt), 64'b0010);
        @(negedge clk);
        #1 chk("bp_next_gnt", 64'(bus.gnt), 64'b0100);
        chk_res("bp_res1", fs[1], fc[1], 2'd1);
        chk("bp_count9", 64'(bus.op_count), 64'd9);
        @(negedge clk);
        bus.req = 4'b0000;
        chk_res("bp_res2", fs[2], fc[2], 2'd2);
        chk("bp_count10", 64'(bus.op_count), 64'd10);
        @(negedge clk);
        chk("bp_count11", 64'(bus.op_count), 64'd11);

        // 5: carry and width corners
        set_op(3, 32'h8000_0000, 32'h8000_0000);
        bus.req = 4'b1000;
        #1 chk("cw_gnt3", 64'(bus.gnt), 64'b1000);
        @(negedge clk);
        set_op(2, 32'h7FFF_FFFF, 32'h0000_0001);
        bus.req = 4'b0100;
        chk_res("cw_res3", 32'h0000_0000, 1'b1, 2'd3);
        #1 chk("cw_gnt2", 64'(bus.gnt), 64'b0100);
        @(negedge clk);
        bus.req = 4'b0000;
        chk_res("cw_res2", 32'h8000_0000, 1'b0, 2'd2);
        chk("cw_count", 64'(bus.op_count), 64'd12);

        // 6: reset while full with requests pending
        bus.req       = 4'b1111;
        bus.res_ready = 1'b0;
        rst_n         = 1'b0;
        #1 chk("rmid_gnt", 64'(bus.gnt), 64'd0);
        @(negedge clk);
        chk("rmid_valid", 64'(bus.res_valid), 64'd0);
        chk("rmid_count", 64'(bus.op_count), 64'd0);
        chk("rmid_sum",   64'(bus.res_sum), 64'd0);
        rst_n         = 1'b1;
        bus.res_ready = 1'b1;
        #1 chk("rmid_ptr_gnt", 64'(bus.gnt), 64'b0001);
        @(negedge clk);
        bus.req = 4'b0000;
        chk_res("rmid_res", fs[0], fc[0], 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
